mem_access_responder: RTL and testbench

- Memory-side responder for the datapath's load/store requests.
- Accepts one request at a time over a REQ/ACK handshake and drives a single 64-bit doubleword memory port (Memoria64-style: registered address, fixed read latency, write on MEM_WR).
- Serves ld/lw/lh/lb (signed and unsigned) and sd/sw/sh/sb.
- Sub-doubleword stores use read-modify-write.

---
 rtl/mem_access_responder.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_responder.sv
// mem_access_responder
//
// Memory-side responder for the datapath's load/store requests. It accepts one
// request at a time over a REQ/ACK handshake and serves it through a single
// 64-bit doubleword memory port. The port has a registered address, a fixed
// read latency and a write strobe. Loads extract a byte, half, word or double
// from the addressed doubleword. Sub-doubleword stores read the doubleword,
// merge the new lanes and write it back. Misaligned accesses are answered with
// ERR and never touch memory.
//
// Ports
//   CLK       in   rising-edge clock
//   RESET     in   synchronous, active-high reset
//   REQ       in   request valid (only looked at while idle)
//   WE        in   1 = store, 0 = load
//   SIZE      in   0 byte, 1 half, 2 word, 3 double
//   UNS       in   1 = zero-extend loads, 0 = sign-extend
//   ADDR      in   byte address
//   WDATA     in   store data, low 8*2^SIZE bits used
//   ACK       out  one-cycle response pulse
//   ERR       out  misaligned access, valid with ACK
//   RDATA     out  load result, held between loads
//   MEM_ADDR  out  doubleword-aligned memory address
//   MEM_WR    out  memory write strobe
//   MEM_DIN   out  memory write data
//   MEM_DOUT  in   memory read data
module mem_access_responder #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              WE,
    input  logic [1:0]        SIZE,
    input  logic              UNS,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [63:0]       WDATA,
    output logic              ACK,
    output logic              ERR,
    output logic [63:0]       RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WR,
    output logic [63:0]       MEM_DIN,
    input  logic [63:0]       MEM_DOUT
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [2:0]        off_q;
    logic [63:0]       wdata_q, buf_q, rdata_q;
    logic [ADDR_W-1:0] memAddr_q;

    logic              reqMisaligned;
    logic [63:0]       lane, loadVal, bitMask, merged;
    logic [7:0]        byteMask;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] alignMask(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Byte lanes covered by an access of the given size, starting at lane 0.
    function automatic logic [7:0] sizeLanes(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    assign reqMisaligned = |(ADDR[2:0] & alignMask(SIZE));

    // Next-state logic. Full doubleword stores skip the read because every
    // byte is overwritten. Everything else that is aligned reads first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (REQ) begin
                    if (reqMisaligned) begin
                        state_d = RESP;
                    end else if (!WE || SIZE != 2'd3) begin
                        state_d = RD_WAIT;
                        cnt_d   = 3'(MEM_LAT);
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = we_q ? WRITE : RESP;
                end
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Load extraction works directly on MEM_DOUT. The read data is only valid
    // in the last RD_WAIT cycle, and RDATA must change together with ACK.
    always_comb begin
        lane    = MEM_DOUT >> {off_q, 3'b000};
        loadVal = lane;
        case (size_q)
            2'd0:    loadVal = {{56{~uns_q & lane[7]}},  lane[7:0]};
            2'd1:    loadVal = {{48{~uns_q & lane[15]}}, lane[15:0]};
            2'd2:    loadVal = {{32{~uns_q & lane[31]}}, lane[31:0]};
            default: loadVal = lane;
        endcase
    end

    // Read-modify-write merge. For a doubleword store the mask covers every
    // lane, so the stale buffer contents drop out completely.
    always_comb begin
        byteMask = sizeLanes(size_q) << off_q;
        bitMask  = '0;
        for (int i = 0; i < 8; i++) begin
            bitMask[8*i +: 8] = {8{byteMask[i]}};
        end
        merged = (buf_q & ~bitMask) | ((wdata_q << {off_q, 3'b000}) & bitMask);
    end

    // State, captured request and read buffer. The request fields are only
    // loaded while idle, so REQ activity during a transfer has no effect.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
            rdata_q   <= '0;
            memAddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && REQ) begin
                we_q      <= WE;
                size_q    <= SIZE;
                uns_q     <= UNS;
                off_q     <= ADDR[2:0];
                wdata_q   <= WDATA;
                err_q     <= reqMisaligned;
                memAddr_q <= {ADDR[ADDR_W-1:3], 3'b000};
            end
            if (state_q == RD_WAIT && cnt_q == 3'd1) begin
                buf_q <= MEM_DOUT;
                if (!we_q) begin
                    rdata_q <= loadVal;
                end
            end
        end
    end

    assign ACK      = (state_q == RESP);
    assign ERR      = (state_q == RESP) && err_q;
    assign MEM_WR   = (state_q == WRITE);
    assign MEM_DIN  = (state_q == WRITE) ? merged : 64'h0;
    assign MEM_ADDR = memAddr_q;
    assign RDATA    = rdata_q;

endmodule

// File: tb/tb_mem_access_responder.sv
// Testbench for mem_access_responder.
// It runs two instances, one with read latency 1 and one with read latency 3.
// Each instance has its own doubleword memory model. A byte-level shadow
// memory predicts load results, merged store data and handshake timing.
module tb_mem_access_responder;

    localparam int NI = 2;

    logic        clk, reset, memClear;
    logic        req   [NI];
    logic        we    [NI];
    logic        uns   [NI];
    logic [1:0]  size  [NI];
    logic [63:0] addr  [NI];
    logic [63:0] wdata [NI];
    logic        ack   [NI];
    logic        err   [NI];
    logic        memWr [NI];
    logic [63:0] rdata   [NI];
    logic [63:0] memAddr [NI];
    logic [63:0] memDin  [NI];
    logic [63:0] memDout [NI];

    logic [63:0] expMem [NI][64];
    logic [63:0] expRdata [NI];
    int nAsserts = 0;
    int nFail = 0;

    // One responder per latency, each with a word-addressed memory model
    // whose read data lags the presented address by MEM_LAT-1 cycles.
    for (genvar g = 0; g < NI; g++) begin : gInst
        localparam int L = (g == 0) ? 1 : 3;
        logic [63:0] mem [64];
        logic [63:0] aPipe [3];

        mem_access_responder #(.MEM_LAT(L), .ADDR_W(64)) dut (
            .CLK(clk), .RESET(reset), .REQ(req[g]), .WE(we[g]), .SIZE(size[g]),
            .UNS(uns[g]), .ADDR(addr[g]), .WDATA(wdata[g]), .ACK(ack[g]),
            .ERR(err[g]), .RDATA(rdata[g]), .MEM_ADDR(memAddr[g]),
            .MEM_WR(memWr[g]), .MEM_DIN(memDin[g]), .MEM_DOUT(memDout[g])
        );

        always @(posedge clk) begin
            if (memClear) begin
                for (int k = 0; k < 64; k++) mem[k] <= 64'h0;
            end else if (memWr[g]) begin
                mem[memAddr[g][8:3]] <= memDin[g];
            end
            aPipe[0] <= memAddr[g];
            aPipe[1] <= aPipe[0];
            aPipe[2] <= aPipe[1];
        end

        if (L == 1) begin : gLat1
            assign memDout[g] = mem[memAddr[g][8:3]];
        end else begin : gLatN
            assign memDout[g] = mem[aPipe[L-2][8:3]];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int latOf(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] modelLoad(input logic [63:0] word, input int off,
                                              input int nb, input logic u);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (!u && nb < 8 && v[8*nb-1]) begin
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic logic [63:0] modelStore(input logic [63:0] word, input int off,
                                               input int nb, input logic [63:0] d);
        logic [63:0] w;
        w = word;
        for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = d[8*i +: 8];
        return w;
    endfunction

    // Issues one request in the current cycle (cycle 0). It watches the DUT up
    // to the predicted ACK cycle and checks timing, data and memory traffic.
    // It returns in the idle cycle after ACK. With busy set, REQ stays high
    // with random fields for the whole transfer.
    task automatic applyStimulus(input int g, input logic w, input logic [1:0] s,
                                 input logic u, input logic [63:0] a, input logic [63:0] d,
                                 input bit busy, output int ackC, output logic [63:0] dinSeen);
        int off, nb, idx, expAckC, expWrC, expWrN, firstAck, ackN, wrN, wrC;
        bit mis;
        logic errSeen;
        logic [63:0] expDin, expVal, rdSeen, addrSeen;

        off = int'(a[2:0]);
        nb  = 1 << s;
        idx = int'(a[8:3]);
        mis = (off % nb) != 0;
        expWrC = -1;
        expWrN = 0;
        if (mis) expAckC = 1;
        else if (!w) expAckC = latOf(g) + 1;
        else if (s == 2'd3) begin expAckC = 2; expWrC = 1; expWrN = 1; end
        else begin expAckC = latOf(g) + 2; expWrC = latOf(g) + 1; expWrN = 1; end
        expDin = modelStore(expMem[g][idx], off, nb, d);
        expVal = (!w && !mis) ? modelLoad(expMem[g][idx], off, nb, u) : expRdata[g];

        req[g] = 1'b1; we[g] = w; size[g] = s; uns[g] = u; addr[g] = a; wdata[g] = d;
        firstAck = -1; ackN = 0; wrN = 0; wrC = -1;
        errSeen = 1'bx; rdSeen = 'x; addrSeen = 'x; dinSeen = 'x;
        for (int c = 1; c <= expAckC; c++) begin
            tick();
            if (ack[g]) begin
                ackN++;
                if (firstAck < 0) begin
                    firstAck = c; errSeen = err[g]; rdSeen = rdata[g]; addrSeen = memAddr[g];
                end
            end
            if (memWr[g]) begin
                wrN++; wrC = c; dinSeen = memDin[g];
            end
            if (busy) begin
                we[g] = 1'($urandom); size[g] = 2'($urandom); uns[g] = 1'($urandom);
                addr[g] = {$urandom, $urandom}; wdata[g] = {$urandom, $urandom};
            end else begin
                req[g] = 1'b0;
            end
        end
        checkOutput("ackCycle", 64'(firstAck), 64'(expAckC));
        checkOutput("ackCount", 64'(ackN), 64'd1);
        checkOutput("err", {63'b0, errSeen}, {63'b0, mis});
        checkOutput("rdata", rdSeen, expVal);
        checkOutput("memAddr", addrSeen, {a[63:3], 3'b000});
        checkOutput("memWrCount", 64'(wrN), 64'(expWrN));
        if (expWrN == 1) begin
            checkOutput("memWrCycle", 64'(wrC), 64'(expWrC));
            checkOutput("memDin", dinSeen, expDin);
        end
        tick();
        checkOutput("ackPulse", {63'b0, ack[g]}, 64'd0);
        if (w && !mis) expMem[g][idx] = expDin;
        expRdata[g] = expVal;
        ackC = firstAck;
    endtask

    task automatic randomTxns(input int g, input int n, input bit busy);
        logic [63:0] a;
        int ac;
        logic [63:0] dn;
        for (int i = 0; i < n; i++) begin
            a = {$urandom, $urandom};
            a[8:3] = 6'($urandom_range(0, 3));
            applyStimulus(g, 1'($urandom), 2'($urandom), 1'($urandom), a,
                          {$urandom, $urandom}, busy, ac, dn);
        end
        req[g] = 1'b0;
    endtask

    initial begin
        int ac, sawAck, sawWr;
        logic [63:0] dn;

        reset = 1'b1; memClear = 1'b1;
        for (int g = 0; g < NI; g++) begin
            req[g] = 1'b0; we[g] = 1'b0; size[g] = '0; uns[g] = 1'b0;
            addr[g] = '0; wdata[g] = '0; expRdata[g] = '0;
            for (int k = 0; k < 64; k++) expMem[g][k] = '0;
        end
        tick();
        tick();
        for (int g = 0; g < NI; g++) begin
            checkOutput("rstAck", {63'b0, ack[g]}, 64'd0);
            checkOutput("rstErr", {63'b0, err[g]}, 64'd0);
            checkOutput("rstRdata", rdata[g], 64'd0);
            checkOutput("rstMemWr", {63'b0, memWr[g]}, 64'd0);
            checkOutput("rstMemAddr", memAddr[g], 64'd0);
            checkOutput("rstMemDin", memDin[g], 64'd0);
        end
        reset = 1'b0; memClear = 1'b0;
        tick();

        $display("[TB] directed loads and stores, latency 1");
        applyStimulus(0, 1'b1, 2'd3, 1'b0, 64'h10, 64'h8877_6655_4433_2211, 1'b0, ac, dn);
        applyStimulus(0, 1'b0, 2'd0, 1'b0, 64'h17, 64'h0, 1'b0, ac, dn);
        checkOutput("lbValue", rdata[0], 64'hFFFF_FFFF_FFFF_FF88);
        checkOutput("lbAckCycle", 64'(ac), 64'd2);
        applyStimulus(0, 1'b0, 2'd0, 1'b1, 64'h17, 64'h0, 1'b0, ac, dn);
        checkOutput("lbuValue", rdata[0], 64'h0000_0000_0000_0088);
        applyStimulus(0, 1'b0, 2'd2, 1'b0, 64'h14, 64'h0, 1'b0, ac, dn);
        checkOutput("lwValue", rdata[0], 64'hFFFF_FFFF_8877_6655);
        applyStimulus(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 1'b0, ac, dn);
        checkOutput("ldValue", rdata[0], 64'h8877_6655_4433_2211);
        applyStimulus(0, 1'b1, 2'd1, 1'b0, 64'h12, 64'h1234_5678_9999_ABCD, 1'b0, ac, dn);
        checkOutput("shDin", dn, 64'h8877_6655_ABCD_2211);
        checkOutput("shAckCycle", 64'(ac), 64'd3);
        applyStimulus(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 1'b0, ac, dn);
        checkOutput("ldAfterSh", rdata[0], 64'h8877_6655_ABCD_2211);
        applyStimulus(0, 1'b1, 2'd3, 1'b0, 64'h20, 64'h0123_4567_89AB_CDEF, 1'b0, ac, dn);
        checkOutput("sdAckCycle", 64'(ac), 64'd2);
        checkOutput("sdRdataHeld", rdata[0], 64'h8877_6655_ABCD_2211);
        applyStimulus(0, 1'b0, 2'd2, 1'b0, 64'h13, 64'h0, 1'b0, ac, dn);
        applyStimulus(0, 1'b1, 2'd1, 1'b0, 64'h21, 64'hFFFF, 1'b0, ac, dn);
        checkOutput("misAckCycle", 64'(ac), 64'd1);
        applyStimulus(0, 1'b0, 2'd3, 1'b0, 64'h20, 64'h0, 1'b0, ac, dn);
        checkOutput("sdMemKept", rdata[0], 64'h0123_4567_89AB_CDEF);

        $display("[TB] latency 3 and REQ held busy");
        applyStimulus(1, 1'b1, 2'd3, 1'b0, 64'h8, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, ac, dn);
        applyStimulus(1, 1'b0, 2'd2, 1'b1, 64'hC, 64'h0, 1'b0, ac, dn);
        checkOutput("lat3AckCycle", 64'(ac), 64'd4);
        checkOutput("lat3Value", rdata[1], 64'h0000_0000_DEAD_BEEF);
        randomTxns(0, 10, 1'b1);
        randomTxns(1, 10, 1'b1);

        $display("[TB] random mix");
        randomTxns(0, 40, 1'b0);
        randomTxns(1, 40, 1'b0);

        $display("[TB] reset during RD_WAIT of sb");
        req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'd0; uns[1] = 1'b0;
        addr[1] = 64'h30; wdata[1] = 64'hFF;
        tick();
        req[1] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rwRstAck", {63'b0, ack[1]}, 64'd0);
        checkOutput("rwRstMemWr", {63'b0, memWr[1]}, 64'd0);
        checkOutput("rwRstRdata1", rdata[1], 64'd0);
        checkOutput("rwRstRdata0", rdata[0], 64'd0);
        checkOutput("rwRstMemAddr", memAddr[1], 64'd0);
        expRdata[0] = '0; expRdata[1] = '0;
        sawAck = 0; sawWr = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack[1]) sawAck++;
            if (memWr[1]) sawWr++;
        end
        checkOutput("rwRstNoAck", 64'(sawAck), 64'd0);
        checkOutput("rwRstNoWr", 64'(sawWr), 64'd0);
        applyStimulus(1, 1'b0, 2'd3, 1'b0, 64'h30, 64'h0, 1'b0, ac, dn);

        $display("[TB] reset during WRITE of sh");
        req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'd1; uns[0] = 1'b0;
        addr[0] = 64'h14; wdata[0] = 64'h5A5A;
        tick();
        req[0] = 1'b0;
        tick();
        checkOutput("wrRstStrobe", {63'b0, memWr[0]}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("wrRstMemWrOff", {63'b0, memWr[0]}, 64'd0);
        checkOutput("wrRstAck", {63'b0, ack[0]}, 64'd0);
        expMem[0][2] = modelStore(expMem[0][2], 4, 2, 64'h5A5A);
        expRdata[0] = '0; expRdata[1] = '0;
        tick();
        applyStimulus(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 1'b0, ac, dn);

        $display("[TB] reset dominates REQ");
        reset = 1'b1; req[0] = 1'b1; we[0] = 1'b0; size[0] = 2'd3; addr[0] = 64'h10;
        tick();
        reset = 1'b0; req[0] = 1'b0;
        sawAck = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack[0]) sawAck++;
        end
        checkOutput("rstReqNoAck", 64'(sawAck), 64'd0);
        expRdata[0] = '0; expRdata[1] = '0;
        applyStimulus(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 1'b0, ac, dn);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
